// File: rtl/power_sched_pkg.sv
// Shared types and sizing helpers for the power measurement scheduler.
package power_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_FLUSH,
    ST_SETTLE,
    ST_FEED,
    ST_WAIT_RESULT,
    ST_STORE
  } state_t;

  // Samples per measurement window for a given log2 window size.
  function automatic int unsigned window_len(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

  // Width of a counter that must be able to hold max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/rr_next_channel.sv
// Round-robin helper: next enabled channel above the pointer, and the
// lowest enabled channel of the mask.
module rr_next_channel #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         i_mask,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [$clog2(NUM_CH)-1:0] o_next_ptr,
  output logic                      o_none,
  output logic [$clog2(NUM_CH)-1:0] o_lowest
);

  localparam int PW = $clog2(NUM_CH);

  // Scan from the top down so the last hit is the lowest qualifying bit.
  always_comb begin
    o_next_ptr = '0;
    o_none     = 1'b1;
    o_lowest   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (i_mask[NUM_CH-1-i]) begin
        o_lowest = PW'(NUM_CH-1-i);
        if (PW'(NUM_CH-1-i) > i_ptr) begin
          o_next_ptr = PW'(NUM_CH-1-i);
          o_none     = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/power_meas_scheduler.sv
// Time-multiplexes one average power detector across NUM_CH channels,
// sweeping enabled channels round-robin and storing one result per channel.
module power_meas_scheduler
  import power_sched_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int AVG_WINDOW_BITS = 10,
  parameter int SETTLE_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [DATA_WIDTH-1:0]        threshold,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_sample_in,
  input  logic [NUM_CH-1:0]            ch_valid_in,
  output logic                         det_flush,
  output logic [DATA_WIDTH-1:0]        det_sample,
  output logic                         det_valid,
  input  logic [DATA_WIDTH-1:0]        det_power_in,
  input  logic                         det_power_valid_in,
  output logic [$clog2(NUM_CH)-1:0]    result_ch,
  output logic [DATA_WIDTH-1:0]        result_power,
  output logic                         result_valid,
  output logic [NUM_CH-1:0]            over_thresh,
  output logic [NUM_CH-1:0]            timeout_err,
  output logic                         busy,
  output logic                         sweep_done
);

  localparam int          PW      = $clog2(NUM_CH);
  localparam int unsigned WIN_LEN = window_len(AVG_WINDOW_BITS);
  localparam int unsigned WW      = AVG_WINDOW_BITS + 1;
  localparam int unsigned TW      = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned SW      = cnt_width(SETTLE_CYCLES);

  state_t                  r_state, w_next_state;
  logic [PW-1:0]           r_ptr;
  logic [NUM_CH-1:0]       r_mask;
  logic                    r_rewind;
  logic [SW-1:0]           r_settle;
  logic [WW-1:0]           r_win;
  logic [TW-1:0]           r_to;
  logic [DATA_WIDTH-1:0]   r_det_sample;
  logic                    r_det_valid;
  logic [PW-1:0]           r_result_ch;
  logic [DATA_WIDTH-1:0]   r_result_power;
  logic [NUM_CH-1:0]       r_over;
  logic [NUM_CH-1:0]       r_timeout_err;
  logic                    r_sweep_done;

  logic [PW-1:0]           w_rr_next, w_rr_lowest;
  logic                    w_none;
  logic                    w_accept_start, w_feed_take, w_window_full, w_timing;
  logic                    w_capture, w_timeout, w_advance, w_sweep_end, w_relatch;
  logic [DATA_WIDTH-1:0]   w_sel_sample;
  state_t                  w_adv_state;

  rr_next_channel #(.NUM_CH(NUM_CH)) u_rr (
    .i_mask    (r_mask),
    .i_ptr     (r_ptr),
    .o_next_ptr(w_rr_next),
    .o_none    (w_none),
    .o_lowest  (w_rr_lowest)
  );

  assign w_sel_sample   = ch_sample_in[r_ptr*DATA_WIDTH +: DATA_WIDTH];
  assign w_accept_start = (r_state == ST_IDLE) && start && (|ch_enable);
  assign w_feed_take    = (r_state == ST_FEED) && ch_valid_in[r_ptr];
  assign w_window_full  = w_feed_take && (r_win == WW'(WIN_LEN - 1));
  assign w_timing       = (r_state == ST_FEED) || (r_state == ST_WAIT_RESULT);
  assign w_capture      = (r_state == ST_WAIT_RESULT) && det_power_valid_in;
  assign w_timeout      = w_timing && !w_capture && (r_to == TW'(TIMEOUT_CYCLES - 1));
  assign w_advance      = (r_state == ST_STORE) || w_timeout;
  assign w_sweep_end    = w_advance && w_none;
  assign w_relatch      = w_sweep_end && continuous && (|ch_enable);
  assign w_adv_state    = (!w_none || w_relatch) ? ST_SELECT : ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    det_flush    = 1'b0;
    result_valid = 1'b0;
    unique case (r_state)
      ST_IDLE:        if (w_accept_start) w_next_state = ST_SELECT;
      ST_SELECT:      w_next_state = ST_FLUSH;
      ST_FLUSH: begin
        det_flush    = 1'b1;
        w_next_state = ST_SETTLE;
      end
      ST_SETTLE:      if (r_settle == SW'(SETTLE_CYCLES - 1)) w_next_state = ST_FEED;
      ST_FEED: begin
        if (w_timeout)          w_next_state = w_adv_state;
        else if (w_window_full) w_next_state = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (w_capture)      w_next_state = ST_STORE;
        else if (w_timeout) w_next_state = w_adv_state;
      end
      ST_STORE: begin
        result_valid = 1'b1;
        w_next_state = w_adv_state;
      end
      default:        w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr          <= '0;
      r_mask         <= '0;
      r_rewind       <= 1'b0;
      r_settle       <= '0;
      r_win          <= '0;
      r_to           <= '0;
      r_det_sample   <= '0;
      r_det_valid    <= 1'b0;
      r_result_ch    <= '0;
      r_result_power <= '0;
      r_over         <= '0;
      r_timeout_err  <= '0;
      r_sweep_done   <= 1'b0;
    end else begin
      r_sweep_done <= w_sweep_end;
      r_det_valid  <= w_feed_take;
      if (w_feed_take) r_det_sample <= w_sel_sample;

      if (w_accept_start) begin
        r_mask        <= ch_enable;
        r_rewind      <= 1'b1;
        r_timeout_err <= '0;
      end

      // A freshly latched mask is resolved to its lowest channel in SELECT,
      // once r_mask already holds the new value.
      if (r_state == ST_SELECT && r_rewind) begin
        r_ptr    <= w_rr_lowest;
        r_rewind <= 1'b0;
      end

      if (r_state == ST_FLUSH)       r_settle <= '0;
      else if (r_state == ST_SETTLE) r_settle <= r_settle + 1'b1;

      if (r_state == ST_SETTLE) begin
        r_win <= '0;
        r_to  <= '0;
      end else begin
        if (w_feed_take) r_win <= r_win + 1'b1;
        if (w_timing)    r_to  <= r_to + 1'b1;
      end

      if (w_capture) begin
        r_result_power <= det_power_in;
        r_result_ch    <= r_ptr;
      end
      if (r_state == ST_STORE) r_over[r_ptr] <= (r_result_power > threshold);
      if (w_timeout)           r_timeout_err[r_ptr] <= 1'b1;

      if (w_advance) begin
        if (!w_none) begin
          r_ptr <= w_rr_next;
        end else if (w_relatch) begin
          r_mask   <= ch_enable;
          r_rewind <= 1'b1;
        end
      end
    end
  end

  assign det_sample   = r_det_sample;
  assign det_valid    = r_det_valid;
  assign result_ch    = r_result_ch;
  assign result_power = r_result_power;
  assign over_thresh  = r_over;
  assign timeout_err  = r_timeout_err;
  assign busy         = (r_state != ST_IDLE);
  assign sweep_done   = r_sweep_done;

endmodule

// File: doc/power_meas_scheduler.md
Name: power_meas_scheduler

Overview:
Time-multiplexes one shared average_power_detector across NUM_CH receive channels. Sweeps the enabled channels in round-robin order. For each channel it flushes the detector, waits a settle period, then feeds exactly 2^AVG_WINDOW_BITS valid samples. It captures the resulting average power into a per-channel result register and flags channels over a programmable threshold. It sits between the channel front-ends (DDC outputs) and the detector, and is controlled by the register/config block.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- DATA_WIDTH, 32, sample and power word width.
- AVG_WINDOW_BITS, 10, log2 of samples per measurement (matches detector).
- SETTLE_CYCLES, 8, idle cycles after flush before feeding.
- TIMEOUT_CYCLES, 4096, maximum cycles waiting in FEED or WAIT_RESULT.

Ports:
- clk in 1: system clock.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse, begins a sweep when idle.
- continuous in 1: when 1, re-start the sweep automatically.
- ch_enable in NUM_CH: channel mask, latched at sweep start.
- threshold in DATA_WIDTH: over-threshold compare level.
- ch_sample_in in NUM_CH*DATA_WIDTH: packed channel samples; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- ch_valid_in in NUM_CH: per-channel sample valid.
- det_flush out 1: one-cycle clear pulse to the detector accumulator.
- det_sample out DATA_WIDTH: sample to the detector.
- det_valid out 1: sample valid to the detector.
- det_power_in in DATA_WIDTH: detector average output.
- det_power_valid_in in 1: detector output valid.
- result_ch out $clog2(NUM_CH): channel of the last result.
- result_power out DATA_WIDTH: last captured power.
- result_valid out 1: one-cycle pulse per stored result.
- over_thresh out NUM_CH: per-channel flag, result_power > threshold, updated on store.
- timeout_err out NUM_CH: sticky per-channel timeout flags.
- busy out 1: high when not IDLE.
- sweep_done out 1: one-cycle pulse at the end of each sweep.

Behaviour:
- Reset: all outputs 0; state IDLE; channel pointer 0; latched mask 0; counters 0. Reset mid-sweep aborts immediately, with no result or sweep_done pulse; the next start re-flushes the detector.
- States: IDLE, SELECT, FLUSH, SETTLE, FEED, WAIT_RESULT, STORE.
- IDLE: on start with nonzero ch_enable, latch the mask, set the pointer to the lowest enabled channel, then go to SELECT. Start with an all-zero mask is ignored. Start while busy is ignored.
- SELECT (1 cycle) -> FLUSH.
- FLUSH (1 cycle): det_flush=1 -> SETTLE.
- SETTLE: hold exactly SETTLE_CYCLES cycles with det_valid=0 -> FEED.
- FEED:
  - det_sample = selected channel sample (registered, 1-cycle latency); det_valid = registered ch_valid_in[ptr].
  - Count accepted valids. After 2^AVG_WINDOW_BITS valids, force det_valid=0 and go to WAIT_RESULT.
  - Other channels' samples are dropped.
- WAIT_RESULT: on det_power_valid_in, capture det_power_in -> STORE. A det_power_valid_in arriving in any other state is ignored.
- Timeout: a single counter resets on entry to FEED and runs through FEED and WAIT_RESULT. Reaching TIMEOUT_CYCLES sets timeout_err[ptr], skips STORE (no result_valid), and advances the pointer.
- STORE (1 cycle):
  - result_valid=1; result_ch=ptr; result_power=captured value; over_thresh[ptr] updated (strict >, unsigned).
  - Advance the pointer to the next enabled channel above ptr.
  - If none remain: pulse sweep_done. Then go to SELECT with the pointer at the lowest enabled channel of the newly latched mask if continuous=1, else go to IDLE.
- continuous is sampled only at sweep end; clearing it mid-sweep lets the current sweep finish.
- ch_enable changes take effect only at the next sweep latch.
- timeout_err bits clear only on rst or on a start pulse accepted from IDLE.
- Single-channel mask: that channel is remeasured each sweep.
- Window counter width is AVG_WINDOW_BITS+1 bits; no wrap occurs inside a window.

Decomposition:
- Package power_sched_pkg: state enum encoding; WINDOW_LEN = 1<<AVG_WINDOW_BITS; counter-width localparams.
- One sub-module, rr_next_channel: purely combinational. Inputs are mask and current pointer; outputs are next pointer, a "wrapped/none" flag, and the lowest set bit.
- Datapath mux and FSM stay in the top module.

Test Plan:
- Bench setup: real average_power_detector instantiated as the DUT's partner.
- Single sweep, mask=4'b0101, channel 0 constant 16, channel 2 constant 64, valid every cycle:
  - two result_valid pulses, ch0 then ch2;
  - result_power equal to the detector's average for each constant;
  - sweep_done one cycle after the second STORE; busy falls; exactly 1024 det_valid per channel.
- Gappy input, ch_valid_in[1] high 1 cycle in 3, mask=4'b0010 -> exactly 1024 det_valid pulses; result stored; no timeout.
- Timeout, mask=4'b0011, ch0 valid never asserted -> timeout_err=2'b01 after 4096 cycles; no result for ch0; ch1 result stored; sweep_done pulses.
- Threshold, threshold=100, ch0 power 50, ch1 power 200 -> over_thresh=4'b0010 after sweep.
- Continuous mode with mask changed mid-sweep from 4'b1111 to 4'b1000:
  - first sweep visits 0,1,2,3;
  - second sweep visits only 3;
  - clearing continuous -> returns to IDLE after the current sweep.
- Control corner cases:
  - rst asserted during FEED -> all outputs 0 next cycle;
  - start with mask 0 -> busy stays 0;
  - start while busy -> no effect.
